mem_bus_responder: RTL and testbench

Data/instruction memory responder on the core's memory bus, replacing the core-internal memory array. It accepts one byte-addressed load or store request at a time over a valid/ready handshake and performs byte-lane masking and load sign/zero extension. It returns a response after a configurable number of wait states. Storage is little-endian, word-organised RAM of 2^ADDR_WIDTH bytes.

---
 rtl/mem_bus_responder_if.sv | 24 ++
 rtl/mem_bus_responder.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_responder.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - request/response bus between core and memory responder
interface mem_bus_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - byte-addressed load/store RAM responder with wait states
module mem_bus_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input logic              clk,
    input logic              rst,
    mem_bus_responder_if.slave bus
);
    localparam int DEPTH     = 1 << (ADDR_WIDTH - 2);
    localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic [31:0] mem [0:DEPTH-1];

    logic [31:0] a_eff;
    logic [31:0] wd_eff;
    logic        we_eff;
    logic        uns_eff;
    logic [1:0]  sz_eff;
    logic        accept;
    logic        exec;
    logic        err;
    logic [ADDR_WIDTH-3:0] idx;
    logic [1:0]  lane;
    logic [31:0] word_rd;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [3:0]  be;
    logic [31:0] wd_al;

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign accept = bus.req_valid && (state == ST_IDLE);
    // The access runs on the edge that enters RESP; never while reset is held.
    assign exec   = !rst && ((accept && (WAIT_CYCLES == 0)) || (state == ST_WAIT && cnt == 4'd0));

    // In IDLE the live request is used so a zero-wait access can execute on acceptance
    always_comb begin
        if (state == ST_IDLE) begin
            a_eff   = bus.req_addr;
            we_eff  = bus.req_we;
            sz_eff  = bus.req_size;
            uns_eff = bus.req_unsigned;
            wd_eff  = bus.req_wdata;
        end else begin
            a_eff   = addr_q;
            we_eff  = we_q;
            sz_eff  = size_q;
            uns_eff = uns_q;
            wd_eff  = wdata_q;
        end
    end

    // Legality: size, natural alignment, and no address bits above the RAM
    always_comb begin
        err = 1'b0;
        if (sz_eff == 2'b11) err = 1'b1;
        if (sz_eff == 2'b01 && a_eff[0]) err = 1'b1;
        if (sz_eff == 2'b10 && a_eff[1:0] != 2'b00) err = 1'b1;
        if ((a_eff >> ADDR_WIDTH) != 32'd0) err = 1'b1;
    end

    assign idx     = a_eff[ADDR_WIDTH-1:2];
    assign lane    = a_eff[1:0];
    assign word_rd = mem[idx];
    assign shifted = word_rd >> {lane, 3'b000};

    // Right-align the addressed lanes and extend to 32 bits
    always_comb begin
        case (sz_eff)
            2'b00:   load_val = uns_eff ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = uns_eff ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = word_rd;
        endcase
    end

    // Byte enables and store data replicated onto every candidate lane
    always_comb begin
        case (sz_eff)
            2'b00: begin
                be    = 4'b0001 << lane;
                wd_al = {4{wd_eff[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wd_al = {2{wd_eff[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wd_al = wd_eff;
            end
        endcase
    end

    // RAM lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (exec && we_eff && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd_al[8*i +: 8];
            end
        end
    end

    // Control FSM, request latches and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q  <= bus.req_addr;
                        we_q    <= bus.req_we;
                        size_q  <= bus.req_size;
                        uns_q   <= bus.req_unsigned;
                        wdata_q <= bus.req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            cnt   <= 4'(WAIT_LOAD);
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (exec) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err;
                rsp_rdata_q <= (err || we_eff) ? 32'd0 : load_val;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - randomized and directed bench for mem_bus_responder
module tb_mem_bus_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // sel=0 talks to the one-wait-state instance, sel=1 to the zero-wait instance
    logic        sel;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    mem_bus_responder_if b1 ();
    mem_bus_responder_if b0 ();

    assign b1.req_valid    = req_valid & ~sel;
    assign b1.req_addr     = req_addr;
    assign b1.req_we       = req_we;
    assign b1.req_size     = req_size;
    assign b1.req_unsigned = req_unsigned;
    assign b1.req_wdata    = req_wdata;
    assign b1.rsp_ready    = rsp_ready & ~sel;
    assign b0.req_valid    = req_valid & sel;
    assign b0.req_addr     = req_addr;
    assign b0.req_we       = req_we;
    assign b0.req_size     = req_size;
    assign b0.req_unsigned = req_unsigned;
    assign b0.req_wdata    = req_wdata;
    assign b0.rsp_ready    = rsp_ready & sel;

    mem_bus_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mem_bus_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

    logic        o_req_ready;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    assign o_req_ready = sel ? b0.req_ready : b1.req_ready;
    assign o_rsp_valid = sel ? b0.rsp_valid : b1.rsp_valid;
    assign o_rsp_rdata = sel ? b0.rsp_rdata : b1.rsp_rdata;
    assign o_rsp_err   = sel ? b0.rsp_err   : b1.rsp_err;

    logic [7:0] ref_mem [0:1][0:4095];

    function automatic int exp_lat();
        return sel ? 1 : 2;
    endfunction

    // Byte-level reference: legality from size/alignment/range, little-endian bytes
    task automatic model(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] wd, output logic e, output logic [31:0] rd);
        int n;
        int s;
        s  = sel ? 1 : 0;
        n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        e  = (sz == 2'b11) || ((a % n) != 0) || (a >= 32'd4096);
        rd = 32'd0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[s][a[11:0] + 12'(i)] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rd = rd | (32'(ref_mem[s][a[11:0] + 12'(i)]) << (8*i));
                if (!uns && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
            end
        end
    endtask

    // Runs one request and reports what the bus showed; lat counts the acceptance cycle
    task automatic xact(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] wd, output bit acc_rdy, output int lat,
                        output logic [31:0] rd, output logic e, output bit rel_ok);
        int k;
        @(negedge clk);
        req_addr = a; req_we = we; req_size = sz; req_unsigned = uns; req_wdata = wd;
        req_valid = 1'b1;
        acc_rdy = (o_req_ready === 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (o_rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        lat = (o_rsp_valid === 1'b1) ? k + 1 : -1;
        rd  = o_rsp_rdata;
        e   = o_rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        rel_ok = (o_rsp_valid === 1'b0 && o_req_ready === 1'b1 && o_rsp_rdata === 32'd0 && o_rsp_err === 1'b0);
    endtask

    task automatic test_reset();
        req_valid = 0; req_addr = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_wdata = 0;
        rsp_ready = 0; sel = 0; rst = 0;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (b1.req_ready !== 1'b1 || b1.rsp_valid !== 1'b0 || b1.rsp_rdata !== 32'd0 || b1.rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_w1: got ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                     b1.req_ready, b1.rsp_valid, b1.rsp_rdata, b1.rsp_err);
        end
        tests++;
        if (b0.req_ready !== 1'b1 || b0.rsp_valid !== 1'b0 || b0.rsp_rdata !== 32'd0 || b0.rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_w0: got ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                     b0.req_ready, b0.rsp_valid, b0.rsp_rdata, b0.rsp_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_init();
        bit acc; int lat; logic [31:0] rd; logic e; bit rel; logic me; logic [31:0] mrd;
        logic [31:0] wd;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < 64; w++) begin
                wd = $urandom;
                model(32'(4*w), 1'b1, 2'b10, 1'b0, wd, me, mrd);
                xact(32'(4*w), 1'b1, 2'b10, 1'b0, wd, acc, lat, rd, e, rel);
                tests++;
                if (!acc || lat != exp_lat() || rd !== mrd || e !== me || !rel) begin
                    fails++;
                    $display("FAIL init sel=%0d addr=%h: got rdata=%h err=%b lat=%0d acc=%0d rel=%0d, want rdata=%h err=%b lat=%0d",
                             sel, 4*w, rd, e, lat, acc, rel, mrd, me, exp_lat());
                end
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [19] = '{32'h064, 32'h064, 32'h065, 32'h064, 32'h065, 32'h065, 32'h066, 32'h066,
                                 32'h066, 32'h064, 32'h066, 32'h065, 32'h064, 32'h1000, 32'h8000_0064,
                                 32'h064, 32'hFFC, 32'hFFE, 32'hFFC};
        bit          tw [19] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
        logic [1:0]  ts [19] = '{2'd2, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1,
                                 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
        bit          tu [19] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic [31:0] td [19] = '{32'h12345678, 0, 32'h777777AB, 0, 0, 0, 32'hFFFF8001, 0, 0, 0, 0,
                                 32'h5555, 0, 0, 32'h0, 0, 32'hCAFEF00D, 0, 0};
        logic [31:0] tr [19] = '{0, 32'h12345678, 0, 32'h1234AB78, 32'hFFFFFFAB, 32'h000000AB, 0,
                                 32'hFFFF8001, 32'h00008001, 32'h8001AB78, 0, 0, 0, 0, 0, 32'h8001AB78,
                                 0, 32'h0000CAFE, 32'h0000000D};
        bit          te [19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        bit acc; int lat; logic [31:0] rd; logic e; bit rel; logic me; logic [31:0] mrd;
        sel = 1'b0;
        for (int i = 0; i < 19; i++) begin
            model(ta[i], tw[i], ts[i], tu[i], td[i], me, mrd);
            xact(ta[i], tw[i], ts[i], tu[i], td[i], acc, lat, rd, e, rel);
            tests++;
            if (!acc || lat != 2 || rd !== tr[i] || e !== te[i] || !rel) begin
                fails++;
                $display("FAIL directed[%0d] addr=%h: got rdata=%h err=%b lat=%0d acc=%0d rel=%0d, want rdata=%h err=%b lat=2",
                         i, ta[i], rd, e, lat, acc, rel, tr[i], te[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic me; logic [31:0] mrd; logic me2; logic [31:0] mrd2;
        int k;
        sel = 1'b0;
        model(32'h064, 1'b0, 2'b10, 1'b0, 32'd0, me, mrd);
        @(negedge clk);
        req_addr = 32'h064; req_we = 0; req_size = 2'b10; req_unsigned = 0; req_wdata = 0; req_valid = 1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (o_rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clk); k++; @(negedge clk);
        end
        // Second request held valid throughout the stalled response
        req_addr = 32'h066; req_size = 2'b00; req_unsigned = 1'b1; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== mrd || o_rsp_err !== me || o_req_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d]: got valid=%b rdata=%h err=%b ready=%b, want 1 %h %b 0",
                         c, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_req_ready, mrd, me);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        tests++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL release: got valid=%b ready=%b, want 0 1", o_rsp_valid, o_req_ready);
        end
        model(32'h066, 1'b0, 2'b00, 1'b1, 32'd0, me2, mrd2);
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (o_rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clk); k++; @(negedge clk);
        end
        tests++;
        if (o_rsp_valid !== 1'b1 || k != 1 || o_rsp_rdata !== mrd2 || o_rsp_err !== me2) begin
            fails++;
            $display("FAIL back_to_back: got valid=%b lat=%0d rdata=%h err=%b, want 1 2 %h %b",
                     o_rsp_valid, k + 1, o_rsp_rdata, o_rsp_err, mrd2, me2);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        bit acc; int lat; logic [31:0] rd; logic e; bit rel; logic me; logic [31:0] mrd;
        int k;
        sel = 1'b0;
        // Reset during WAIT: the store never happens
        @(negedge clk);
        req_addr = 32'h070; req_we = 1; req_size = 2'b10; req_unsigned = 0; req_wdata = 32'hDEADBEEF; req_valid = 1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_rdata !== 32'd0 || o_rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_in_wait: got valid=%b ready=%b rdata=%h err=%b, want 0 1 00000000 0",
                     o_rsp_valid, o_req_ready, o_rsp_rdata, o_rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        model(32'h070, 1'b0, 2'b10, 1'b0, 32'd0, me, mrd);
        xact(32'h070, 1'b0, 2'b10, 1'b0, 32'd0, acc, lat, rd, e, rel);
        tests++;
        if (!acc || lat != 2 || rd !== mrd || e !== me || !rel) begin
            fails++;
            $display("FAIL after_wait_rst: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=2", rd, e, lat, mrd, me);
        end
        // Reset during RESP: the store already landed
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (o_rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clk); k++; @(negedge clk);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_rdata !== 32'd0 || o_rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_in_resp: got valid=%b ready=%b rdata=%h err=%b, want 0 1 00000000 0",
                     o_rsp_valid, o_req_ready, o_rsp_rdata, o_rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        model(32'h070, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, me, mrd);
        xact(32'h070, 1'b0, 2'b10, 1'b0, 32'd0, acc, lat, rd, e, rel);
        tests++;
        if (!acc || lat != 2 || rd !== 32'hDEADBEEF || e !== 1'b0 || !rel) begin
            fails++;
            $display("FAIL after_resp_rst: got rdata=%h err=%b lat=%0d, want rdata=deadbeef err=0 lat=2", rd, e, lat);
        end
        // Zero-wait instance: one-cycle latency store then load
        sel = 1'b1;
        model(32'h070, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, me, mrd);
        xact(32'h070, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, acc, lat, rd, e, rel);
        tests++;
        if (!acc || lat != 1 || rd !== 32'd0 || e !== 1'b0 || !rel) begin
            fails++;
            $display("FAIL w0_store: got rdata=%h err=%b lat=%0d, want rdata=00000000 err=0 lat=1", rd, e, lat);
        end
        xact(32'h070, 1'b0, 2'b10, 1'b0, 32'd0, acc, lat, rd, e, rel);
        tests++;
        if (!acc || lat != 1 || rd !== 32'hDEADBEEF || e !== 1'b0 || !rel) begin
            fails++;
            $display("FAIL w0_load: got rdata=%h err=%b lat=%0d, want rdata=deadbeef err=0 lat=1", rd, e, lat);
        end
    endtask

    task automatic test_random();
        bit acc; int lat; logic [31:0] rd; logic e; bit rel; logic me; logic [31:0] mrd;
        logic [31:0] a; logic we; logic [1:0] sz; logic uns; logic [31:0] wd;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int n = 0; n < 150; n++) begin
                a   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
                we  = 1'($urandom_range(0, 1));
                sz  = 2'($urandom_range(0, 3));
                uns = 1'($urandom_range(0, 1));
                wd  = $urandom;
                model(a, we, sz, uns, wd, me, mrd);
                xact(a, we, sz, uns, wd, acc, lat, rd, e, rel);
                tests++;
                if (!acc || lat != exp_lat() || rd !== mrd || e !== me || !rel) begin
                    fails++;
                    $display("FAIL rand sel=%0d addr=%h we=%b size=%0d uns=%b: got rdata=%h err=%b lat=%0d acc=%0d rel=%0d, want rdata=%h err=%b lat=%0d",
                             sel, a, we, sz, uns, rd, e, lat, acc, rel, mrd, me, exp_lat());
                end
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
